// File: rtl/accum_pkg.sv
// Shared types and defaults for the sample accumulator.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } accum_state_t;

   localparam int DEFAULT_NUM_SAMPLES = 4;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple adder wrapper used as the accumulator datapath.
module adder_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carry_in,
   output logic [7:0] sum,
   output logic       carry_out
);

   logic [8:0] w_full;

   assign w_full    = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
   assign sum       = w_full[7:0];
   assign carry_out = w_full[8];

endmodule

// File: rtl/sample_accumulator.sv
// Sums NUM_SAMPLES bytes through adder_8bit and holds the total
// with a sticky overflow flag under a valid/ack handshake.
module sample_accumulator
   import accum_pkg::*;
#(
   parameter int NUM_SAMPLES = DEFAULT_NUM_SAMPLES
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clear,
   input  logic       data_valid,
   input  logic [7:0] data_in,
   output logic       data_ready,
   output logic [7:0] result,
   output logic       result_valid,
   input  logic       result_ack,
   output logic       overflow_flag,
   output logic [7:0] sample_count
);

   localparam logic [7:0] LP_LAST = 8'(NUM_SAMPLES);

   accum_state_t r_state;
   accum_state_t w_state_nxt;

   logic [7:0] r_acc;
   logic [7:0] r_count;
   logic [7:0] r_result;
   logic       r_ovf;

   logic [7:0] w_sum;
   logic       w_carry;
   logic [7:0] w_count_inc;
   logic       w_accept;
   logic       w_last;
   logic       w_take;

   adder_8bit u_adder (
      .a         (r_acc),
      .b         (data_in),
      .carry_in  (1'b0),
      .sum       (w_sum),
      .carry_out (w_carry)
   );

   assign w_count_inc = r_count + 8'd1;
   assign w_accept    = data_valid & data_ready;
   assign w_last      = (w_count_inc == LP_LAST);
   assign w_take      = (r_state == DONE) & result_ack;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE, ACCUM: begin
               if (w_accept) begin
                  w_state_nxt = w_last ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (result_ack) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      data_ready   = (r_state != DONE);
      result_valid = (r_state == DONE);
   end

   // Accept cannot coincide with ack: data_ready is low in DONE.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_acc    <= 8'd0;
         r_count  <= 8'd0;
         r_result <= 8'd0;
         r_ovf    <= 1'b0;
      end else if (clear) begin
         r_acc    <= 8'd0;
         r_count  <= 8'd0;
         r_result <= 8'd0;
         r_ovf    <= 1'b0;
      end else if (w_take) begin
         r_acc   <= 8'd0;
         r_count <= 8'd0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_acc   <= w_sum;
         r_count <= w_count_inc;
         r_ovf   <= r_ovf | w_carry;
         if (w_last) begin
            r_result <= w_sum;
         end
      end
   end

   assign result        = r_result;
   assign overflow_flag = r_ovf;
   assign sample_count  = r_count;

endmodule

// File: tb/tb_sample_accumulator.sv
// Directed scoreboard bench for sample_accumulator (N=4 and N=1).
module tb_sample_accumulator;

   typedef struct {
      logic [7:0] res;
      logic       ovf;
   } exp_t;

   logic       clk;
   logic       n_rst;
   logic       clear;
   logic       data_valid;
   logic [7:0] data_in;
   logic       data_ready;
   logic [7:0] result;
   logic       result_valid;
   logic       result_ack;
   logic       overflow_flag;
   logic [7:0] sample_count;

   logic       clear1;
   logic       data_valid1;
   logic [7:0] data_in1;
   logic       data_ready1;
   logic [7:0] result1;
   logic       result_valid1;
   logic       result_ack1;
   logic       overflow_flag1;
   logic [7:0] sample_count1;

   int vectors = 0;
   int errors  = 0;

   exp_t sb[$];
   exp_t e;

   int         m_cnt;
   logic [7:0] m_acc;
   logic       m_ovf;

   sample_accumulator #(.NUM_SAMPLES(4)) u_dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .data_valid    (data_valid),
      .data_in       (data_in),
      .data_ready    (data_ready),
      .result        (result),
      .result_valid  (result_valid),
      .result_ack    (result_ack),
      .overflow_flag (overflow_flag),
      .sample_count  (sample_count)
   );

   sample_accumulator #(.NUM_SAMPLES(1)) u_dut1 (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear1),
      .data_valid    (data_valid1),
      .data_in       (data_in1),
      .data_ready    (data_ready1),
      .result        (result1),
      .result_valid  (result_valid1),
      .result_ack    (result_ack1),
      .overflow_flag (overflow_flag1),
      .sample_count  (sample_count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_acc = 8'd0;
      m_ovf = 1'b0;
   endtask

   // One accepted byte on the N=4 instance; model predicts the total.
   task automatic send(input logic [7:0] d);
      logic [8:0] s;
      data_valid = 1'b1;
      data_in    = d;
      s     = {1'b0, m_acc} + {1'b0, d};
      m_acc = s[7:0];
      m_ovf = m_ovf | s[8];
      m_cnt++;
      if (m_cnt == 4) begin
         e.res = m_acc;
         e.ovf = m_ovf;
         sb.push_back(e);
      end
      tick();
      data_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag);
      exp_t x;
      for (int i = 0; i < 8 && !result_valid; i++) tick();
      chk({tag, "_valid"}, 32'(result_valid), 32'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         chk({tag, "_result"}, 32'(result), 32'(x.res));
         chk({tag, "_ovf"}, 32'(overflow_flag), 32'(x.ovf));
         chk({tag, "_ready"}, 32'(data_ready), 32'd0);
      end
   endtask

   task automatic ack();
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      model_reset();
   endtask

   initial begin
      n_rst       = 1'b0;
      clear       = 1'b0;
      data_valid  = 1'b0;
      data_in     = 8'd0;
      result_ack  = 1'b0;
      clear1      = 1'b0;
      data_valid1 = 1'b0;
      data_in1    = 8'd0;
      result_ack1 = 1'b0;
      model_reset();
      #12;
      chk("rst_valid", 32'(result_valid), 32'd0);
      chk("rst_count", 32'(sample_count), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_ready", 32'(data_ready), 32'd1);
      n_rst = 1'b1;
      tick();

      // 1: async reset mid-accumulation
      send(8'd10);
      send(8'd20);
      chk("t1_count", 32'(sample_count), 32'd2);
      #2 n_rst = 1'b0;
      #1;
      chk("t1_valid", 32'(result_valid), 32'd0);
      chk("t1_count0", 32'(sample_count), 32'd0);
      chk("t1_ovf", 32'(overflow_flag), 32'd0);
      chk("t1_ready", 32'(data_ready), 32'd1);
      model_reset();
      n_rst = 1'b1;
      tick();

      // 2: basic
      send(8'd10);
      send(8'd20);
      send(8'd30);
      send(8'd40);
      expect_result("t2");
      chk("t2_abs", 32'(result), 32'd100);
      ack();
      chk("t2_ack_valid", 32'(result_valid), 32'd0);
      chk("t2_hold", 32'(result), 32'd100);

      // 3: wrap with sticky overflow
      send(8'd200);
      send(8'd100);
      chk("t3_ovf_mid", 32'(overflow_flag), 32'd1);
      send(8'd1);
      send(8'd1);
      expect_result("t3");
      chk("t3_abs", 32'(result), 32'd46);
      ack();
      chk("t3_ack_ovf", 32'(overflow_flag), 32'd0);
      chk("t3_ack_ready", 32'(data_ready), 32'd1);
      chk("t3_ack_count", 32'(sample_count), 32'd0);

      // 4: backpressure in DONE
      send(8'd1);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      expect_result("t4");
      data_valid = 1'b1;
      data_in    = 8'd7;
      for (int i = 0; i < 5; i++) tick();
      chk("t4_bp_count", 32'(sample_count), 32'd4);
      chk("t4_bp_valid", 32'(result_valid), 32'd1);
      chk("t4_bp_result", 32'(result), 32'd4);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      chk("t4_ready", 32'(data_ready), 32'd1);
      chk("t4_count0", 32'(sample_count), 32'd0);
      tick();
      data_valid = 1'b0;
      chk("t4_count1", 32'(sample_count), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_reset();
      chk("t4_clr_count", 32'(sample_count), 32'd0);

      // 5: clear collides with a sample
      send(8'd5);
      send(8'd5);
      clear      = 1'b1;
      data_valid = 1'b1;
      data_in    = 8'd9;
      tick();
      clear      = 1'b0;
      data_valid = 1'b0;
      model_reset();
      chk("t5_count", 32'(sample_count), 32'd0);
      chk("t5_result", 32'(result), 32'd0);
      chk("t5_ready", 32'(data_ready), 32'd1);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      expect_result("t5");
      chk("t5_abs", 32'(result), 32'd4);
      ack();

      // 6: gaps between samples
      for (int k = 1; k <= 4; k++) begin
         send(8'(k));
         if (k < 4) begin
            for (int g = 0; g < 3; g++) tick();
            chk("t6_gap_count", 32'(sample_count), 32'(k));
         end
      end
      expect_result("t6");
      chk("t6_abs", 32'(result), 32'd10);
      ack();

      // 6b: NUM_SAMPLES=1
      chk("n1_ready", 32'(data_ready1), 32'd1);
      data_valid1 = 1'b1;
      data_in1    = 8'd255;
      tick();
      data_valid1 = 1'b0;
      chk("n1_valid", 32'(result_valid1), 32'd1);
      chk("n1_result", 32'(result1), 32'd255);
      chk("n1_ovf", 32'(overflow_flag1), 32'd0);
      chk("n1_count", 32'(sample_count1), 32'd1);
      result_ack1 = 1'b1;
      tick();
      result_ack1 = 1'b0;
      chk("n1_ack_valid", 32'(result_valid1), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
